rtc_op_scheduler: RTL and testbench

Decides when the RTC access FSMs run. Periodically launches a refresh sequence (read hour, read date, optionally read timer) and inserts user-requested RTC writes between reads. Produces one-cycle start pulses for the worker FSMs, including the `do_it_leer_hora` input of the hour reader. Also drives the select for the shared `a_d/cs/rd/wr` bus mux, held for the full duration of each operation.

---
 rtl/rtc_op_scheduler_pkg.sv | 44 ++++
 rtl/rtc_op_scheduler_if.sv | 28 ++
 rtl/rtc_op_scheduler_refresh_timer.sv | 38 +++
 rtl/rtc_op_scheduler.sv | 142 ++++++++++++++
 tb/tb_rtc_op_scheduler.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/rtc_op_scheduler_pkg.sv
// Shared types for the RTC operation scheduler: FSM states, operation codes
// (which double as the bus-mux select values) and write targets.
// Build option: RTC_TIMER_READ_EN adds a timer read to each refresh sequence.
package rtc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_HORA  = 2'd0,
    OP_FECHA = 2'd1,
    OP_TIMER = 2'd2,
    OP_ESC   = 2'd3
  } op_t;

  localparam logic [1:0] SEL_HORA  = 2'd0;
  localparam logic [1:0] SEL_FECHA = 2'd1;
  localparam logic [1:0] SEL_TIMER = 2'd2;

  // Index of the final read in a refresh sequence.
`ifdef RTC_TIMER_READ_EN
  localparam logic [1:0] LAST_SEQ_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_SEQ_IDX = 2'd1;
`endif

  // The unused target code 3 falls back to the hour registers.
  function automatic logic [1:0] norm_sel(input logic [1:0] sel);
    return (sel == 2'd3) ? SEL_HORA : sel;
  endfunction

  // Position within the refresh sequence -> read operation.
  function automatic op_t seq_op(input logic [1:0] idx);
    case (idx)
      2'd0:    return OP_HORA;
      2'd1:    return OP_FECHA;
      default: return OP_TIMER;
    endcase
  endfunction

endpackage

// File: rtl/rtc_op_scheduler_if.sv
// Request/start-pulse bundle between the scheduler and its environment.
// The slave side is the scheduler; the master side drives requests and
// observes the worker start pulses and bus-mux select.
interface rtc_op_scheduler_if;
  logic       init_done;
  logic       wr_req;
  logic [1:0] wr_sel;
  logic       do_it_leer_hora;
  logic       do_it_leer_fecha;
  logic       do_it_leer_timer;
  logic       do_it_escribir;
  logic [1:0] esc_sel;
  logic [1:0] mux_sel;
  logic       wr_ack;
  logic       busy;

  modport master (
    output init_done, wr_req, wr_sel,
    input  do_it_leer_hora, do_it_leer_fecha, do_it_leer_timer, do_it_escribir,
    input  esc_sel, mux_sel, wr_ack, busy
  );

  modport slave (
    input  init_done, wr_req, wr_sel,
    output do_it_leer_hora, do_it_leer_fecha, do_it_leer_timer, do_it_escribir,
    output esc_sel, mux_sel, wr_ack, busy
  );
endinterface

// File: rtl/rtc_op_scheduler_refresh_timer.sv
// Refresh period counter: free-runs 0..REFRESH_CYCLES-1 once the RTC is
// initialised and emits a one-cycle tick in the cycle it wraps.
module rtc_refresh_timer
  import rtc_sched_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic init_done,
  output logic tick
);

  localparam logic [31:0] CNT_LAST = 32'(REFRESH_CYCLES - 1);

  logic [31:0] cnt_q, cnt_d;

  // Next count: parked at zero until init completes, wraps with a tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!init_done) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_op_scheduler.sv
// RTC operation scheduler: launches periodic refresh reads (hour, date and,
// with RTC_TIMER_READ_EN defined, timer) and slots user writes in between.
// Each operation is a one-cycle start pulse followed by a fixed guard window
// during which mux_sel keeps the shared RTC bus pointed at that worker.
module rtc_op_scheduler
  import rtc_sched_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1_000_000,
  parameter int GUARD_CYCLES   = 40
) (
  input  logic                clk,
  input  logic                reset,
  rtc_op_scheduler_if.slave   bus
);

  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);

  logic        tick;
  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  seq_idx_q, seq_idx_d;
  logic        refresh_pend_q, refresh_pend_d;
  logic        wr_pend_q, wr_pend_d;
  logic [1:0]  wr_sel_q, wr_sel_d;
  logic [1:0]  esc_sel_q, esc_sel_d;
  logic        issue;
  logic        is_write;

  rtc_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk       (clk),
    .reset     (reset),
    .init_done (bus.init_done),
    .tick      (tick)
  );

  // Next-state logic: operation sequencing plus pending-request bookkeeping.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wait_cnt_d     = wait_cnt_q;
    seq_idx_d      = seq_idx_q;
    refresh_pend_d = refresh_pend_q;
    wr_pend_d      = wr_pend_q;
    wr_sel_d       = wr_sel_q;
    esc_sel_d      = esc_sel_q;

    case (state_q)
      IDLE: begin
        // A pending write wins every operation boundary.
        if (bus.init_done) begin
          if (wr_pend_q) begin
            op_d    = OP_ESC;
            state_d = ISSUE;
          end else if (refresh_pend_q) begin
            op_d    = seq_op(seq_idx_q);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
        if (op_q == OP_ESC) begin
          esc_sel_d = wr_sel_q;
          wr_pend_d = 1'b0;
        end else begin
          seq_idx_d = seq_idx_q + 2'd1;
          if (seq_idx_q == LAST_SEQ_IDX) refresh_pend_d = 1'b0;
        end
      end
      WAIT: begin
        if (wait_cnt_q == GUARD_LAST) state_d = IDLE;
        else                          wait_cnt_d = wait_cnt_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase

    // A wrap during an unfinished sequence is dropped rather than restarting it.
    if (tick && !refresh_pend_q) begin
      refresh_pend_d = 1'b1;
      seq_idx_d      = '0;
    end

    // New requests override the clear from a write being issued this cycle.
    if (bus.init_done && bus.wr_req) begin
      wr_pend_d = 1'b1;
      wr_sel_d  = norm_sel(bus.wr_sel);
    end

    // Losing init abandons all pending work; the running operation finishes.
    if (!bus.init_done) begin
      wr_pend_d      = 1'b0;
      refresh_pend_d = 1'b0;
      seq_idx_d      = '0;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= OP_HORA;
      wait_cnt_q     <= '0;
      seq_idx_q      <= '0;
      refresh_pend_q <= 1'b0;
      wr_pend_q      <= 1'b0;
      wr_sel_q       <= SEL_HORA;
      esc_sel_q      <= SEL_HORA;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      wait_cnt_q     <= wait_cnt_d;
      seq_idx_q      <= seq_idx_d;
      refresh_pend_q <= refresh_pend_d;
      wr_pend_q      <= wr_pend_d;
      wr_sel_q       <= wr_sel_d;
      esc_sel_q      <= esc_sel_d;
    end
  end

  assign issue    = (state_q == ISSUE);
  assign is_write = (op_q == OP_ESC);

  assign bus.do_it_leer_hora  = issue && (op_q == OP_HORA);
  assign bus.do_it_leer_fecha = issue && (op_q == OP_FECHA);
`ifdef RTC_TIMER_READ_EN
  assign bus.do_it_leer_timer = issue && (op_q == OP_TIMER);
`else
  assign bus.do_it_leer_timer = 1'b0;
`endif
  assign bus.do_it_escribir   = issue && is_write;
  assign bus.wr_ack           = issue && is_write;
  // Show the new target already in the write pulse cycle, then hold it.
  assign bus.esc_sel          = (issue && is_write) ? wr_sel_q : esc_sel_q;
  // op_q is loaded on entry to ISSUE and held until the next operation.
  assign bus.mux_sel          = op_q;
  assign bus.busy             = (state_q != IDLE);

endmodule

// File: tb/tb_rtc_op_scheduler.sv
// Scoreboard bench for rtc_op_scheduler (REFRESH_CYCLES=200, GUARD_CYCLES=40).
// Stimulus pushes hand-computed expected start pulses (op, cycle, esc_sel);
// a negedge monitor pops one entry per observed pulse and compares.
module tb_rtc_op_scheduler;
  import rtc_sched_pkg::*;

  localparam int RC = 200;
  localparam int GC = 40;

  typedef struct {
    int         kind;
    int         at;
    logic [1:0] esc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  rtc_op_scheduler_if bus ();

  rtc_op_scheduler #(
    .REFRESH_CYCLES(RC),
    .GUARD_CYCLES  (GC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int k, input int at, input logic [1:0] esc);
    exp_t e;
    e.kind = k;
    e.at   = at;
    e.esc  = esc;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] sel);
    bus.wr_req = 1'b1;
    bus.wr_sel = sel;
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
  endtask

  function automatic int pulses();
    return $countones({bus.do_it_leer_hora, bus.do_it_leer_fecha,
                       bus.do_it_leer_timer, bus.do_it_escribir});
  endfunction

  // Monitor: every start pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int   np;
    int   kind;
    exp_t e;
    if (!reset) begin
      np = pulses();
      if (np > 1) check("single_pulse", np, 1);
      if (np >= 1) begin
        kind = bus.do_it_leer_hora  ? 0 :
               bus.do_it_leer_fecha ? 1 :
               bus.do_it_leer_timer ? 2 : 3;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", kind, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("op_kind", kind, e.kind);
          check("op_cycle", cyc, e.at);
          check("mux_sel", bus.mux_sel, e.kind);
          check("wr_ack", bus.wr_ack, (e.kind == 3) ? 1 : 0);
          check("busy_issue", bus.busy, 1);
          if (e.kind == 3) check("esc_sel", bus.esc_sel, e.esc);
          $display("op %0d at cycle %0d mux %0d esc %0d (expected op %0d at %0d)",
                   kind, cyc, bus.mux_sel, bus.esc_sel, e.kind, e.at);
        end
      end
    end
  end

  initial begin
    int r, s, u;
    bus.init_done = 1'b1;
    bus.wr_req    = 1'b0;
    bus.wr_sel    = 2'd0;

    // Reset state
    wait_cyc(3);
    check("rst_busy", bus.busy, 0);
    check("rst_mux", bus.mux_sel, 0);
    check("rst_esc", bus.esc_sel, 0);
    check("rst_pulses", pulses(), 0);
    wait_cyc(5);
    reset = 1'b0;
    r = cyc;

    // First refresh sequence: wrap ends cycle r+199, hora at r+201
    push(0, r + 201, 2'd0);
    push(1, r + 243, 2'd0);
`ifdef RTC_TIMER_READ_EN
    push(2, r + 285, 2'd0);
`endif
    wait_cyc(r + 200);
    check("busy_before_refresh", bus.busy, 0);

    // Write splits the second refresh
    push(0, r + 401, 2'd0);
    push(3, r + 443, 2'd1);
    push(1, r + 485, 2'd0);
`ifdef RTC_TIMER_READ_EN
    push(2, r + 527, 2'd0);
`endif
    wait_cyc(r + 410);
    wr(2'd1);

    // Write latency from IDLE, then the delayed third refresh
    wait_cyc(r + 570);
    push(3, r + 572, 2'd1);
    push(0, r + 614, 2'd0);
    wr(2'd1);

    // Coalescing: sel 0 then sel 2 during hora -> one write with esc_sel 2
    push(3, r + 656, 2'd2);
    push(1, r + 698, 2'd0);
`ifdef RTC_TIMER_READ_EN
    push(2, r + 740, 2'd0);
`endif
    wait_cyc(r + 620);
    wr(2'd0);
    wait_cyc(r + 625);
    wr(2'd2);

    // mux_sel and esc_sel hold after the guard window
    wait_cyc(r + 790);
    check("busy_idle", bus.busy, 0);
`ifdef RTC_TIMER_READ_EN
    check("mux_hold", bus.mux_sel, 2);
`else
    check("mux_hold", bus.mux_sel, 1);
`endif
    check("esc_hold", bus.esc_sel, 2);

    // init_done drops mid-WAIT: hora finishes, nothing further
    push(0, r + 801, 2'd0);
    wait_cyc(r + 810);
    bus.init_done = 1'b0;
    wait_cyc(r + 815);
    wr(2'd1);
    wait_cyc(r + 841);
    check("busy_last_wait", bus.busy, 1);
    wait_cyc(r + 842);
    check("busy_fall", bus.busy, 0);
    wait_cyc(r + 1100);
    bus.init_done = 1'b1;
    s = cyc;

    // wr_sel=3 maps to 0, then a sel-2 write interrupted by reset
    wait_cyc(s + 10);
    push(3, s + 12, 2'd0);
    wr(2'd3);
    wait_cyc(s + 60);
    push(3, s + 62, 2'd2);
    wr(2'd2);
    wait_cyc(s + 80);
    reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_mux", bus.mux_sel, 0);
    check("midrst_esc", bus.esc_sel, 0);
    check("midrst_pulses", pulses(), 0);
    wait_cyc(s + 85);
    reset = 1'b0;
    u = cyc;

    // After reset the first pulse is the first wrap's hora
    push(0, u + 201, 2'd0);
    wait_cyc(u + 200);
    check("busy_after_rst", bus.busy, 0);
    wait_cyc(u + 210);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
